// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: one-entry sample buffer feeding a 32-bit MSB-first
// shifter, with SCLK/LRCLK derived from clk by a programmable divider.
module audio_i2s_tx #(
    parameter int SCLK_DIV = 4,
    parameter bit LJ       = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic signed [15:0] left,
    input  logic signed [15:0] right,
    output logic               i2s_sclk,
    output logic               i2s_lrclk,
    output logic               i2s_data,
    output logic               frame_start,
    output logic               underrun
);

    localparam int DATA_W = 16;

    logic [7:0]              div_cnt;
    logic [4:0]              bit_cnt;
    logic [4:0]              bit_nxt;
    logic [2*DATA_W-1:0]     shift;
    logic [2*DATA_W-1:0]     shift_nxt;
    logic [2*DATA_W-1:0]     last_pair;
    logic signed [DATA_W-1:0] left_buf;
    logic signed [DATA_W-1:0] right_buf;
    logic                    full;
    logic                    full_nxt;
    logic                    tick;
    logic                    fall;
    logic                    load;
    logic                    accept;

    // Philips mode moves word select one bit ahead of the data it frames.
    function automatic logic lrclk_of(input logic [4:0] b);
        logic [4:0] ahead;
        ahead = b + 5'd1;
        return LJ ? b[4] : ahead[4];
    endfunction

    assign full   = ~sample_ready;
    assign tick   = (div_cnt == 8'(SCLK_DIV - 1));
    assign fall   = tick & i2s_sclk;
    assign load   = fall & (bit_cnt == 5'd31);
    assign accept = sample_valid & sample_ready;

    always_comb begin
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        full_nxt  = full;
        if (load) begin
            bit_nxt   = 5'd0;
            shift_nxt = full ? {left_buf, right_buf} : last_pair;
        end else if (fall) begin
            bit_nxt   = bit_cnt + 5'd1;
            shift_nxt = {shift[2*DATA_W-2:0], 1'b0};
        end
        // Load sees the pre-accept buffer state, so an accept always wins here.
        if (accept) begin
            full_nxt = 1'b1;
        end else if (load) begin
            full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt      <= '0;
            i2s_sclk     <= 1'b0;
            bit_cnt      <= 5'd31;
            shift        <= '0;
            last_pair    <= '0;
            left_buf     <= '0;
            right_buf    <= '0;
            sample_ready <= 1'b1;
            i2s_data     <= 1'b0;
            i2s_lrclk    <= LJ;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            div_cnt      <= tick ? 8'd0 : div_cnt + 8'd1;
            sample_ready <= ~full_nxt;
            frame_start  <= load;
            underrun     <= load & ~full;
            if (tick) begin
                i2s_sclk <= ~i2s_sclk;
            end
            if (accept) begin
                left_buf  <= left;
                right_buf <= right;
            end
            if (load && full) begin
                last_pair <= {left_buf, right_buf};
            end
            if (fall) begin
                bit_cnt   <= bit_nxt;
                shift     <= shift_nxt;
                i2s_data  <= shift_nxt[2*DATA_W-1];
                i2s_lrclk <= lrclk_of(bit_nxt);
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: scoreboard of accepted pairs checked against the
// serial stream, plus a left-justified instance for word-select timing.
module tb_audio_i2s_tx;

    localparam int DIV   = 2;
    localparam int FRAME = 64 * DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               i2s_sclk, i2s_lrclk, i2s_data, frame_start, underrun;

    logic               v1;
    logic               ready1;
    logic signed [15:0] left1, right1;
    logic               sclk1, lr1, data1, fs1, ur1;

    audio_i2s_tx #(.SCLK_DIV(DIV), .LJ(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .left(left), .right(right),
        .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data),
        .frame_start(frame_start), .underrun(underrun)
    );

    audio_i2s_tx #(.SCLK_DIV(DIV), .LJ(1'b1)) dut_lj (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(v1), .sample_ready(ready1),
        .left(left1), .right(right1),
        .i2s_sclk(sclk1), .i2s_lrclk(lr1), .i2s_data(data1),
        .frame_start(fs1), .underrun(ur1)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_exp  = '0;
    logic [31:0] cur_exp   = '0;
    logic [31:0] got       = '0;
    logic [31:0] pend_pair = '0;
    bit          pend_valid = 1'b0;
    bit          active = 1'b0;
    int          nbits = 0;
    logic        prev_sclk = 1'b0;
    int          last_fs = -1;

    bit          active1 = 1'b0;
    int          idx1 = 0;
    logic        prev_sclk1 = 1'b0;
    logic        prev_lr1 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Philips-mode monitor: frame boundaries, underrun, serial data, word select.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            exp_q.delete();
            last_exp   = '0;
            active     = 1'b0;
            nbits      = 0;
            prev_sclk  = 1'b0;
            pend_valid = 1'b0;
            last_fs    = -1;
        end else begin
            if (i2s_sclk && !prev_sclk && active && nbits < 32) begin
                chk("lrclk_lj0", i2s_lrclk, ((nbits + 1) % 32) >= 16);
                got = {got[30:0], i2s_data};
                nbits++;
                if (nbits == 32) chk("frame_data", got, cur_exp);
            end
            prev_sclk = i2s_sclk;
            if (frame_start) begin
                if (active) chk("bits_per_frame", nbits, 32);
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
                last_fs = cyc;
                if (exp_q.size() > 0) begin
                    cur_exp = exp_q.pop_front();
                    chk("underrun_loaded", underrun, 1'b0);
                end else begin
                    cur_exp = last_exp;
                    chk("underrun_empty", underrun, 1'b1);
                end
                last_exp = cur_exp;
                active   = 1'b1;
                nbits    = 0;
                got      = '0;
            end else begin
                chk("underrun_idle", underrun, 1'b0);
            end
            if (pend_valid) begin
                exp_q.push_back(pend_pair);
                pend_valid = 1'b0;
            end
        end
    end

    // Left-justified monitor: word select falls with the left MSB, high for 16 SCLK.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            active1    = 1'b0;
            idx1       = 0;
            prev_sclk1 = 1'b0;
        end else begin
            if (sclk1 && !prev_sclk1 && active1 && idx1 < 32) begin
                chk("lrclk_lj1", lr1, idx1 >= 16);
                idx1++;
            end
            prev_sclk1 = sclk1;
            if (fs1) begin
                chk("lj1_lr_fall", {prev_lr1, lr1}, 2'b10);
                active1 = 1'b1;
                idx1    = 0;
            end
        end
        prev_lr1 = lr1;
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc_cyc);
        int w;
        w = 0;
        while (!sample_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", sample_ready, 1'b1);
        sample_valid = 1'b1;
        left  = l;
        right = r;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        pend_pair    = {l, r};
        pend_valid   = 1'b1;
        acc_cyc      = cyc;
        chk("ready_low_after_accept", sample_ready, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk"},  i2s_sclk, 1'b0);
        chk({tag, "_data"},  i2s_data, 1'b0);
        chk({tag, "_lrclk"}, i2s_lrclk, 1'b0);
        chk({tag, "_fs"},    frame_start, 1'b0);
        chk({tag, "_ur"},    underrun, 1'b0);
        chk({tag, "_ready"}, sample_ready, 1'b1);
        chk({tag, "_lj_lrclk"}, lr1, 1'b1);
        chk({tag, "_lj_sclk"},  sclk1, 1'b0);
    endtask

    initial begin
        int a, prev, rel;
        bit found;
        logic [15:0] l, r;
        sample_valid = 1'b0;
        left   = '0;
        right  = '0;
        v1     = 1'b0;
        left1  = '0;
        right1 = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // First pair accepted on clk 1, first load on clk 2*DIV.
        reset_n = 1'b1;
        rel = cyc;
        send(16'hA5F0, 16'h0F0F, a);
        chk("accept_clk1", a - rel, 1);
        @(posedge clk);
        @(posedge clk);
        #1 chk("fs_before_clk4", frame_start, 1'b0);
        @(posedge clk);
        #1 chk("fs_at_clk4", frame_start, 1'b1);
        chk("ur_at_clk4", underrun, 1'b0);

        // Back-to-back stream ending with 1234/5678.
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            l = (k == 5) ? 16'h1234 : 16'(16'h1000 + k);
            r = (k == 5) ? 16'h5678 : 16'(16'h2000 + k);
            send(l, r, a);
            if (k >= 2) chk("accept_interval", a - prev, FRAME);
            prev = a;
        end

        // Supply stops: the next frame repeats the last pair with an underrun pulse.
        found = 1'b0;
        for (int w = 0; w < 400 && !found; w++) begin
            @(negedge clk);
            if (frame_start && underrun) found = 1'b1;
        end
        chk("underrun_seen", found, 1'b1);
        @(negedge clk);
        chk("underrun_one_clk", underrun, 1'b0);

        // Accept exactly on the load cycle with the buffer empty.
        repeat (126) @(negedge clk);
        sample_valid = 1'b1;
        left  = 16'hAAAA;
        right = 16'h5555;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        pend_pair    = 32'hAAAA5555;
        pend_valid   = 1'b1;
        chk("coinc_fs", frame_start, 1'b1);
        chk("coinc_ur", underrun, 1'b1);
        chk("coinc_full", sample_ready, 1'b0);

        // Buffer a pair, then reset mid-frame at bit 20.
        send(16'hBEEF, 16'hCAFE, a);
        found = 1'b0;
        for (int w = 0; w < 400 && !found; w++) begin
            @(negedge clk);
            if (nbits == 21 && !sample_ready) found = 1'b1;
        end
        chk("reach_bit20", found, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("post_reset_fs", frame_start, 1'b1);
        chk("post_reset_ur", underrun, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
